// File: rtl/hist_readout_drain.sv
// Histogram readout/drain stage: on a stop4calc rising edge, sweeps every bin,
// streams each count over valid/ready, clears the bin after acceptance, and
// accumulates total and peak statistics for the window.
module hist_readout_drain #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 4,
   parameter int unsigned TOT_W  = 12
) (
   input  logic              clk200,
   input  logic              rst,
   input  logic              stop4calc,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              mem_clr_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_bin,
   output logic [DATA_W-1:0] out_count,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic [TOT_W-1:0]  total_count,
   output logic [ADDR_W-1:0] peak_bin,
   output logic [DATA_W-1:0] peak_count
);

   localparam int unsigned SUM_W = TOT_W + 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      LATCH   = 3'd2,
      PRESENT = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              stop_q;
   logic              start;
   logic              is_last;
   logic [ADDR_W-1:0] counter;
   logic [SUM_W-1:0]  sum_ext;
   logic [TOT_W-1:0]  sum_sat;

   // Edge detect, last-bin flag and saturating total update
   always_comb begin
      start   = stop4calc & ~stop_q;
      is_last = (counter == {ADDR_W{1'b1}});
      sum_ext = SUM_W'(total_count) + SUM_W'(mem_rd_data);
      sum_sat = sum_ext[TOT_W] ? {TOT_W{1'b1}} : sum_ext[TOT_W-1:0];
   end

   // State register
   always_ff @(posedge clk200 or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = READ;
         READ:    state_nxt = LATCH;
         LATCH:   state_nxt = PRESENT;
         PRESENT: if (out_ready) state_nxt = is_last ? DONE : READ;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes and status decoded from state; clear fires in the handshake cycle
   always_comb begin
      mem_addr   = '0;
      mem_rd_en  = 1'b0;
      mem_clr_en = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         READ: begin
            mem_rd_en = 1'b1;
            mem_addr  = counter;
            busy      = 1'b1;
         end
         LATCH: busy = 1'b1;
         PRESENT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_last  = is_last;
            if (out_ready) begin
               mem_clr_en = 1'b1;
               mem_addr   = counter;
            end
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Address counter, record capture and window statistics
   always_ff @(posedge clk200 or posedge rst) begin
      if (rst) begin
         stop_q      <= 1'b0;
         counter     <= '0;
         out_bin     <= '0;
         out_count   <= '0;
         total_count <= '0;
         peak_bin    <= '0;
         peak_count  <= '0;
      end else begin
         stop_q <= stop4calc;
         case (state)
            IDLE: begin
               if (start) begin
                  counter     <= '0;
                  total_count <= '0;
                  peak_bin    <= '0;
                  peak_count  <= '0;
               end
            end
            LATCH: begin
               out_count   <= mem_rd_data;
               out_bin     <= counter;
               total_count <= sum_sat;
               // strictly greater keeps the lowest index on ties
               if (mem_rd_data > peak_count) begin
                  peak_count <= mem_rd_data;
                  peak_bin   <= counter;
               end
            end
            PRESENT: begin
               if (out_ready && !is_last) counter <= counter + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
